// File: rtl/sysid_checker_pkg.sv
// Shared types and helpers for the system-ID checker: FSM states, Avalon word
// addresses and the stall-timer width calculation.
package sysid_checker_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    GAP   = 3'd3,
    CHECK = 3'd4,
    FIN   = 3'd5
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Retry counter is sized for the full 0..15 range of allowed retries.
  localparam int RETRY_W = 4;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) begin
      width++;
    end
    return width;
  endfunction

  // The timer must be able to hold TIMEOUT_CYCLES itself.
  function automatic int timer_width(input int timeout_cycles);
    int width;
    width = clog2(timeout_cycles + 1);
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/sysid_wait_timer.sv
// Stall counter for one Avalon read: counts cycles spent under waitrequest and
// flags the cycle in which the stall reaches TIMEOUT_CYCLES.
module sysid_wait_timer
  import sysid_checker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int W              = timer_width(TIMEOUT_CYCLES)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  // count_next already includes the current stalled cycle, so the abort lands
  // on the edge that ends the TIMEOUT_CYCLES-th stall and the strobe is high
  // for exactly that many cycles.
  assign count_next = enable ? (count_reg + W'(1)) : count_reg;
  assign expired    = enable && (count_next == LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the sysid ID and timestamp words, compares them
// against the expected build values and holds a latched pass/fail status.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1417958911,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout
);

  localparam int                 TIMER_W     = timer_width(TIMEOUT_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  state_t             state_reg;
  logic               auto_pending_reg;
  logic [RETRY_W-1:0] retries_reg;
  logic               avm_address_reg;
  logic               avm_read_reg;
  logic [31:0]        id_value_reg;
  logic [31:0]        ts_value_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               id_match_reg;
  logic               ts_match_reg;
  logic               timeout_reg;

  logic               start_req;
  logic               launch;
  logic               xfer_done;
  logic               stalled;
  logic               timer_clear;
  logic               timer_expired;
  logic               retries_exhausted;
  logic [3:0]         id_byte_eq;
  logic [3:0]         ts_byte_eq;

  assign start_req         = start | auto_pending_reg;
  assign launch            = (state_reg == IDLE) && start_req;
  assign xfer_done         = avm_read_reg & ~avm_waitrequest;
  assign stalled           = avm_read_reg & avm_waitrequest;
  assign timer_clear       = launch | xfer_done | timer_expired;
  assign retries_exhausted = (retries_reg == RETRY_LIMIT);

  sysid_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .W              (TIMER_W)
  ) u_wait_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (stalled),
    .expired (timer_expired)
  );

  // Full 32-bit equality, split per byte to keep each compare shallow.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_cmp
      assign id_byte_eq[gi] = (id_value_reg[8*gi +: 8] == EXPECTED_ID[8*gi +: 8]);
      assign ts_byte_eq[gi] = (ts_value_reg[8*gi +: 8] == EXPECTED_TS[8*gi +: 8]);
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      auto_pending_reg <= AUTO_START;
      retries_reg      <= '0;
      avm_address_reg  <= ADDR_ID;
      avm_read_reg     <= 1'b0;
      id_value_reg     <= '0;
      ts_value_reg     <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      id_match_reg     <= 1'b0;
      ts_match_reg     <= 1'b0;
      timeout_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_req) begin
            state_reg        <= RD_ID;
            auto_pending_reg <= 1'b0;
            retries_reg      <= '0;
            avm_address_reg  <= ADDR_ID;
            avm_read_reg     <= 1'b1;
            id_value_reg     <= '0;
            ts_value_reg     <= '0;
            busy_reg         <= 1'b1;
            id_match_reg     <= 1'b0;
            ts_match_reg     <= 1'b0;
            timeout_reg      <= 1'b0;
          end
        end

        RD_ID, RD_TS: begin
          if (xfer_done) begin
            retries_reg <= '0;
            if (state_reg == RD_ID) begin
              id_value_reg    <= avm_readdata;
              avm_address_reg <= ADDR_TS;
              state_reg       <= RD_TS;
            end else begin
              ts_value_reg <= avm_readdata;
              avm_read_reg <= 1'b0;
              state_reg    <= CHECK;
            end
          end else if (timer_expired) begin
            // Abort: either give up with a timeout or drop the strobe for one
            // cycle and re-issue the same word. avm_address is left untouched.
            avm_read_reg <= 1'b0;
            if (retries_exhausted) begin
              timeout_reg <= 1'b1;
              busy_reg    <= 1'b0;
              done_reg    <= 1'b1;
              state_reg   <= FIN;
            end else begin
              retries_reg <= retries_reg + RETRY_W'(1);
              state_reg   <= GAP;
            end
          end
        end

        GAP: begin
          avm_read_reg <= 1'b1;
          state_reg    <= (avm_address_reg == ADDR_ID) ? RD_ID : RD_TS;
        end

        CHECK: begin
          id_match_reg <= &id_byte_eq;
          ts_match_reg <= &ts_byte_eq;
          busy_reg     <= 1'b0;
          done_reg     <= 1'b1;
          state_reg    <= FIN;
        end

        // A start arriving here is deliberately dropped.
        FIN: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg    <= IDLE;
          avm_read_reg <= 1'b0;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign avm_address = avm_address_reg;
  assign avm_read    = avm_read_reg;
  assign id_value    = id_value_reg;
  assign ts_value    = ts_value_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign id_match    = id_match_reg;
  assign ts_match    = ts_match_reg;
  assign timeout     = timeout_reg;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: a vector table of slave responses plus
// hand-written sequences for start filtering, mid-transfer reset and timeouts.
module tb_sysid_checker;

  localparam logic [31:0] EXP_TS = 32'd1417958911;

  typedef struct {
    logic [31:0] id_word;
    logic [31:0] ts_word;
    int          stall;
    logic        exp_id_match;
    logic        exp_ts_match;
    int          exp_latency;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;

  // Instance A: default parameters, slave with programmable timestamp stall.
  logic        reset_n_a;
  logic        start_a;
  logic        addr_a;
  logic        read_a;
  logic        wait_a;
  logic [31:0] rdata_a;
  logic [31:0] id_a;
  logic [31:0] ts_a;
  logic        busy_a;
  logic        done_a;
  logic        idm_a;
  logic        tsm_a;
  logic        to_a;

  logic [31:0] id_word;
  logic [31:0] ts_word;
  int          stall_n;
  int          stall_seen = 0;

  assign rdata_a = addr_a ? ts_word : id_word;
  assign wait_a  = read_a && addr_a && (stall_seen < stall_n);

  always @(posedge clock) begin
    if (!read_a) stall_seen <= 0;
    else if (wait_a) stall_seen <= stall_seen + 1;
  end

  sysid_checker dut_a (
    .clock           (clock),
    .reset_n         (reset_n_a),
    .start           (start_a),
    .avm_address     (addr_a),
    .avm_read        (read_a),
    .avm_waitrequest (wait_a),
    .avm_readdata    (rdata_a),
    .id_value        (id_a),
    .ts_value        (ts_a),
    .busy            (busy_a),
    .done            (done_a),
    .id_match        (idm_a),
    .ts_match        (tsm_a),
    .timeout         (to_a)
  );

  // Instance B: short timeout with a slave whose waitrequest is stuck high.
  logic        reset_n_b;
  logic        start_b;
  logic        addr_b;
  logic        read_b;
  logic        stuck_b;
  logic [31:0] rdata_b;
  logic [31:0] id_b;
  logic [31:0] ts_b;
  logic        busy_b;
  logic        done_b;
  logic        idm_b;
  logic        tsm_b;
  logic        to_b;

  assign rdata_b = 32'h0000_0000;

  sysid_checker #(
    .TIMEOUT_CYCLES (8),
    .MAX_RETRIES    (2)
  ) dut_b (
    .clock           (clock),
    .reset_n         (reset_n_b),
    .start           (start_b),
    .avm_address     (addr_b),
    .avm_read        (read_b),
    .avm_waitrequest (stuck_b),
    .avm_readdata    (rdata_b),
    .id_value        (id_b),
    .ts_value        (ts_b),
    .busy            (busy_b),
    .done            (done_b),
    .id_match        (idm_b),
    .ts_match        (tsm_b),
    .timeout         (to_b)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Optionally pulse start, then count negedges until done; lat=-1 on expiry.
  task automatic run_a(input bit do_start, output int lat, output int ts_reads);
    lat      = -1;
    ts_reads = 0;
    if (do_start) start_a = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      start_a = 1'b0;
      if (read_a && addr_a) ts_reads++;
      if (done_a) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[7];

  initial begin
    int  lat;
    int  ts_reads;
    bit  found;
    int  run;
    int  bursts;
    int  min_len;
    int  max_len;
    int  zeros;
    bit  seen_read;
    bit  addr_seen;

    vecs[0] = '{32'd0,          EXP_TS,                 0,  1'b1, 1'b1, 4};
    vecs[1] = '{32'd0,          32'h5441_0000,          0,  1'b1, 1'b0, 4};
    vecs[2] = '{32'd0,          EXP_TS,                 10, 1'b1, 1'b1, 14};
    vecs[3] = '{32'd1,          EXP_TS,                 0,  1'b0, 1'b1, 4};
    vecs[4] = '{32'h8000_0000,  EXP_TS ^ 32'd1,         0,  1'b0, 1'b0, 4};
    vecs[5] = '{32'd0,          EXP_TS ^ 32'h8000_0000, 3,  1'b1, 1'b0, 7};
    vecs[6] = '{32'hFFFF_FFFF,  EXP_TS,                 0,  1'b0, 1'b1, 4};

    reset_n_a = 1'b0;
    reset_n_b = 1'b0;
    start_a   = 1'b0;
    start_b   = 1'b0;
    stuck_b   = 1'b1;
    id_word   = vecs[0].id_word;
    ts_word   = vecs[0].ts_word;
    stall_n   = 0;

    repeat (3) @(negedge clock);
    check("rst_read",     32'(read_a), 32'd0);
    check("rst_address",  32'(addr_a), 32'd0);
    check("rst_busy",     32'(busy_a), 32'd0);
    check("rst_done",     32'(done_a), 32'd0);
    check("rst_id_match", 32'(idm_a),  32'd0);
    check("rst_ts_match", 32'(tsm_a),  32'd0);
    check("rst_timeout",  32'(to_a),   32'd0);
    check("rst_id_value", id_a,        32'd0);
    check("rst_ts_value", ts_a,        32'd0);

    // Vector 0 is the automatic post-reset check; the rest use a start pulse.
    for (int i = 0; i < 7; i++) begin
      id_word = vecs[i].id_word;
      ts_word = vecs[i].ts_word;
      stall_n = vecs[i].stall;
      if (i == 0) begin
        reset_n_a = 1'b1;
        run_a(1'b0, lat, ts_reads);
      end else begin
        run_a(1'b1, lat, ts_reads);
      end
      $display("vec %0d: id=%08h ts=%08h stall=%0d lat=%0d ts_reads=%0d id_match=%b ts_match=%b timeout=%b",
               i, id_a, ts_a, vecs[i].stall, lat, ts_reads, idm_a, tsm_a, to_a);
      check($sformatf("v%0d_latency", i),  32'(lat),      32'(vecs[i].exp_latency));
      check($sformatf("v%0d_ts_reads", i), 32'(ts_reads), 32'(vecs[i].stall + 1));
      check($sformatf("v%0d_id_value", i), id_a,          vecs[i].id_word);
      check($sformatf("v%0d_ts_value", i), ts_a,          vecs[i].ts_word);
      check($sformatf("v%0d_id_match", i), 32'(idm_a),    32'(vecs[i].exp_id_match));
      check($sformatf("v%0d_ts_match", i), 32'(tsm_a),    32'(vecs[i].exp_ts_match));
      check($sformatf("v%0d_timeout", i),  32'(to_a),     32'd0);
      check($sformatf("v%0d_busy_fin", i), 32'(busy_a),   32'd0);
      @(negedge clock);
      check($sformatf("v%0d_done_pulse", i), 32'(done_a), 32'd0);
      @(negedge clock);
    end

    // Start while busy and start during FIN are both dropped.
    id_word = 32'd0;
    ts_word = EXP_TS;
    stall_n = 0;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    check("t5_busy_rd_id", 32'(busy_a), 32'd1);
    @(negedge clock);
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    @(negedge clock);
    check("t5_done_at_4", 32'(done_a), 32'd1);
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    check("t5_fin_start_busy", 32'(busy_a), 32'd0);
    check("t5_fin_start_read", 32'(read_a), 32'd0);
    @(negedge clock);
    run_a(1'b1, lat, ts_reads);
    $display("t5 second check: lat=%0d id_match=%b ts_match=%b", lat, idm_a, tsm_a);
    check("t5_second_latency",  32'(lat),   32'd4);
    check("t5_second_id_match", 32'(idm_a), 32'd1);
    check("t5_second_ts_match", 32'(tsm_a), 32'd1);
    @(negedge clock);
    @(negedge clock);

    // Reset asserted while the timestamp read is stalled.
    stall_n = 50;
    start_a = 1'b1;
    found   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      start_a = 1'b0;
      if (read_a && addr_a) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_reached_rd_ts", 32'(found), 32'd1);
    repeat (3) @(negedge clock);
    check("t6_still_stalled", 32'(read_a), 32'd1);
    #1 reset_n_a = 1'b0;
    #1;
    $display("t6 reset mid-transfer: read=%b busy=%b id_match=%b ts_match=%b", read_a, busy_a, idm_a, tsm_a);
    check("t6_async_read",    32'(read_a), 32'd0);
    check("t6_async_address", 32'(addr_a), 32'd0);
    check("t6_async_busy",    32'(busy_a), 32'd0);
    check("t6_async_done",    32'(done_a), 32'd0);
    check("t6_async_id_match",32'(idm_a),  32'd0);
    check("t6_async_ts_match",32'(tsm_a),  32'd0);
    check("t6_async_timeout", 32'(to_a),   32'd0);
    stall_n = 0;
    @(negedge clock);
    reset_n_a = 1'b1;
    run_a(1'b0, lat, ts_reads);
    $display("t6 rerun: lat=%0d id_match=%b ts_match=%b", lat, idm_a, tsm_a);
    check("t6_rerun_latency",  32'(lat),   32'd4);
    check("t6_rerun_id_match", 32'(idm_a), 32'd1);
    check("t6_rerun_ts_match", 32'(tsm_a), 32'd1);
    check("t6_rerun_timeout",  32'(to_a),  32'd0);

    // Stuck waitrequest on instance B: 3 bursts of 8 with 1-cycle gaps, then timeout.
    @(negedge clock);
    reset_n_b = 1'b1;
    lat       = -1;
    run       = 0;
    bursts    = 0;
    min_len   = 1000;
    max_len   = 0;
    zeros     = 0;
    seen_read = 1'b0;
    addr_seen = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clock);
      if (addr_b) addr_seen = 1'b1;
      if (done_b) begin
        if (run > 0) begin
          bursts++;
          if (run < min_len) min_len = run;
          if (run > max_len) max_len = run;
        end
        lat = c;
        break;
      end
      if (read_b) begin
        run++;
        seen_read = 1'b1;
      end else begin
        if (run > 0) begin
          bursts++;
          if (run < min_len) min_len = run;
          if (run > max_len) max_len = run;
          run = 0;
        end
        if (seen_read) zeros++;
      end
    end
    $display("t4 timeout: done_at=%0d bursts=%0d len=%0d..%0d gaps=%0d timeout=%b busy=%b",
             lat, bursts, min_len, max_len, zeros, to_b, busy_b);
    check("t4_done_cycle",   32'(lat),       32'd27);
    check("t4_bursts",       32'(bursts),    32'd3);
    check("t4_burst_min",    32'(min_len),   32'd8);
    check("t4_burst_max",    32'(max_len),   32'd8);
    check("t4_gap_cycles",   32'(zeros),     32'd2);
    check("t4_address_id",   32'(addr_seen), 32'd0);
    check("t4_timeout",      32'(to_b),      32'd1);
    check("t4_busy",         32'(busy_b),    32'd0);
    check("t4_id_match",     32'(idm_b),     32'd0);
    check("t4_ts_match",     32'(tsm_b),     32'd0);
    check("t4_id_value",     id_b,           32'd0);
    check("t4_ts_value",     ts_b,           32'd0);
    @(negedge clock);
    check("t4_done_pulse",   32'(done_b),    32'd0);
    check("t4_timeout_held", 32'(to_b),      32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
